// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment scan driver:
//   - scan_state_e : scan FSM states (BLANK gap, ON slot)
//   - GLYPH_*      : active-low segment patterns, bit order g..a
//   - SEG_OFF / SEL_OFF : all-dark segment and digit-enable patterns
//   - DP_MASK      : digit positions whose decimal point is lit (hh.mm.ss)
//   - idx_to_sel / dp_lit : small helpers mapping a digit index to its
//                           active-low enable and its decimal-point flag
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_e;

    // Active-low glyphs, bit 6 = g ... bit 0 = a
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [7:0] SEG_OFF  = {1'b1, GLYPH_BLANK};
    localparam logic [5:0] SEL_OFF  = 6'h3F;
    localparam logic [5:0] DP_MASK  = 6'b010100;
    localparam logic [2:0] LAST_IDX = 3'd5;

    // Active-low one-hot digit enable for a scan index; out-of-range is dark.
    function automatic logic [5:0] idx_to_sel(input logic [2:0] idx);
        logic [5:0] sel_v;
        case (idx)
            3'd0:    sel_v = 6'b111110;
            3'd1:    sel_v = 6'b111101;
            3'd2:    sel_v = 6'b111011;
            3'd3:    sel_v = 6'b110111;
            3'd4:    sel_v = 6'b101111;
            3'd5:    sel_v = 6'b011111;
            default: sel_v = SEL_OFF;
        endcase
        return sel_v;
    endfunction

    // Returns 1 when the decimal point is lit after this digit.
    function automatic logic dp_lit(input logic [2:0] idx);
        logic dp_v;
        case (idx)
            3'd0:    dp_v = DP_MASK[0];
            3'd1:    dp_v = DP_MASK[1];
            3'd2:    dp_v = DP_MASK[2];
            3'd3:    dp_v = DP_MASK[3];
            3'd4:    dp_v = DP_MASK[4];
            3'd5:    dp_v = DP_MASK[5];
            default: dp_v = 1'b0;
        endcase
        return dp_v;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD to seven-segment decoder (active-low, g..a).
// Values 10..15 are not valid BCD and are shown as a dash (segment g only).
// Ports:
//   bcd   in  4  digit value
//   glyph out 7  active-low segment pattern, bit 6 = g, bit 0 = a
// -----------------------------------------------------------------------------
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    // Glyph lookup; anything outside 0..9 falls through to the dash.
    always_comb begin
        glyph = GLYPH_DASH;
        case (bcd)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_drv.sv
// -----------------------------------------------------------------------------
// seg_scan_drv
// Multiplexed driver for a 6-digit common-anode seven-segment display.
// Scans the six BCD time digits, one ON slot of SCAN_CYCLES per digit,
// separated by an all-dark gap of BLANK_CYCLES to prevent ghosting.
// The digit value is captured on entering its ON slot and held for the
// whole slot. Decimal points are lit after digits 2 and 4 (hh.mm.ss).
//
// Optional feature macro: SEG_BLINK_EN
//   When defined, the digit selected by edit_sel blinks while edit_en is
//   high (visible half-period first after each edit_en rise). When
//   undefined, no blink logic exists and edit_en/edit_sel are ignored.
//
// Ports:
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous active-low reset
//   sec_l..hour_h in 4 each  BCD digits, scan index 0..5 in that order
//   edit_en   in   1  set mode active
//   edit_sel  in   3  index of the digit being edited
//   seg       out  8  seg[7] = dp, seg[6:0] = g..a, active-low, registered
//   sel       out  6  one-hot active-low digit enable, registered
// -----------------------------------------------------------------------------
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES  = 50_000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] min_l,
    input  logic [3:0] min_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] hour_h,
    input  logic       edit_en,
    input  logic [2:0] edit_sel,
    output logic [7:0] seg,
    output logic [5:0] sel
);

    // One shared slot counter serves both states, sized for the longer one.
    localparam int unsigned SLOT_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W    = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    scan_state_e      state_r;
    scan_state_e      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic [3:0]       digit_r;
    logic [3:0]       digit_nxt_s;
    logic [3:0]       digit_in_s;
    logic [6:0]       glyph_s;
    logic             hide_s;
    logic [7:0]       seg_r;
    logic [7:0]       seg_nxt_s;
    logic [5:0]       sel_r;
    logic [5:0]       sel_nxt_s;

    // Select the input digit belonging to the current scan index.
    always_comb begin
        digit_in_s = 4'd0;
        case (idx_r)
            3'd0:    digit_in_s = sec_l;
            3'd1:    digit_in_s = sec_h;
            3'd2:    digit_in_s = min_l;
            3'd3:    digit_in_s = min_h;
            3'd4:    digit_in_s = hour_l;
            3'd5:    digit_in_s = hour_h;
            default: digit_in_s = 4'd0;
        endcase
    end

    // Scan FSM next state; the digit is captured only on the BLANK->ON edge.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        idx_nxt_s   = idx_r;
        digit_nxt_s = digit_r;
        case (state_r)
            BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_nxt_s = ON;
                    cnt_nxt_s   = CNT_ZERO;
                    digit_nxt_s = digit_in_s;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            ON: begin
                if (cnt_r == SCAN_LAST) begin
                    state_nxt_s = BLANK;
                    cnt_nxt_s   = CNT_ZERO;
                    idx_nxt_s   = (idx_r == LAST_IDX) ? 3'd0 : (idx_r + 3'd1);
                end else begin
                    state_nxt_s = ON;
                end
            end
            default: begin
                state_nxt_s = BLANK;
                cnt_nxt_s   = CNT_ZERO;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    // Decoder sits on the value that will be held in digit_r, so the
    // registered segment pattern lines up with the ON entry edge.
    bcd_to_seg u_bcd_to_seg (
        .bcd   (digit_nxt_s),
        .glyph (glyph_s)
    );

`ifdef SEG_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_ZERO = BLINK_W'(0);

    logic               edit_en_r;
    logic               edit_rise_s;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [BLINK_W-1:0] blink_cnt_nxt_s;
    logic               phase_r;
    logic               phase_nxt_s;

    // Blink timebase; an edit_en rise restarts it in the visible phase.
    always_comb begin
        edit_rise_s     = edit_en & ~edit_en_r;
        blink_cnt_nxt_s = blink_cnt_r + BLINK_ONE;
        phase_nxt_s     = phase_r;
        if (edit_rise_s) begin
            blink_cnt_nxt_s = BLINK_ZERO;
            phase_nxt_s     = 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_nxt_s = BLINK_ZERO;
            phase_nxt_s     = ~phase_r;
        end else begin
            phase_nxt_s     = phase_r;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edit_en_r   <= 1'b0;
            blink_cnt_r <= BLINK_ZERO;
            phase_r     <= 1'b1;
        end else begin
            edit_en_r   <= edit_en;
            blink_cnt_r <= blink_cnt_nxt_s;
            phase_r     <= phase_nxt_s;
        end
    end

    // Hide the edited digit in the dark phase; edit_sel 6/7 never matches.
    always_comb begin
        hide_s = 1'b0;
        if (edit_en && (edit_sel == idx_nxt_s) && !phase_nxt_s) begin
            hide_s = 1'b1;
        end else begin
            hide_s = 1'b0;
        end
    end
`else
    localparam int unsigned BLINK_CYCLES_UNUSED = BLINK_CYCLES;
    logic edit_unused_s;

    // Set-mode inputs have no effect in this build.
    assign edit_unused_s = ^{edit_en, edit_sel};
    assign hide_s        = 1'b0;
`endif

    // Output patterns are computed from the next state so that the
    // registered outputs change exactly on the state-transition edges.
    always_comb begin
        seg_nxt_s = SEG_OFF;
        sel_nxt_s = SEL_OFF;
        if (state_nxt_s == ON) begin
            sel_nxt_s = idx_to_sel(idx_nxt_s);
            if (hide_s) begin
                seg_nxt_s = SEG_OFF;
            end else begin
                seg_nxt_s = {~dp_lit(idx_nxt_s), glyph_s};
            end
        end else begin
            seg_nxt_s = SEG_OFF;
            sel_nxt_s = SEL_OFF;
        end
    end

    // Scan state and registered outputs; reset blanks the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BLANK;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            digit_r <= 4'd0;
            seg_r   <= SEG_OFF;
            sel_r   <= SEL_OFF;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            digit_r <= digit_nxt_s;
            seg_r   <= seg_nxt_s;
            sel_r   <= sel_nxt_s;
        end
    end

    assign seg = seg_r;
    assign sel = sel_r;

endmodule

// File: tb/tb_seg_scan_drv.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_drv
// Self-checking bench for seg_scan_drv with SCAN=8, BLANK=2, BLINK=32.
// A reference model pushes the expected {sel, seg} after every clock edge
// into a queue; each scenario task pops and compares on the falling edge and
// adds its own scenario-specific checks.
// -----------------------------------------------------------------------------
module tb_seg_scan_drv;

    localparam int SCAN  = 8;
    localparam int BLNK  = 2;
    localparam int BLINK = 32;
    localparam int SLOT  = SCAN + BLNK;
    localparam int FRAME = 6 * SLOT;

    logic       clk;
    logic       rst_n;
    logic [3:0] sec_l, sec_h, min_l, min_h, hour_l, hour_h;
    logic       edit_en;
    logic [2:0] edit_sel;
    logic [7:0] seg;
    logic [5:0] sel;

    int checks = 0;
    int errors = 0;
    logic [13:0] sb_q[$];

    seg_scan_drv #(
        .SCAN_CYCLES  (SCAN),
        .BLANK_CYCLES (BLNK),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_l    (sec_l),
        .sec_h    (sec_h),
        .min_l    (min_l),
        .min_h    (min_h),
        .hour_l   (hour_l),
        .hour_h   (hour_h),
        .edit_en  (edit_en),
        .edit_sel (edit_sel),
        .seg      (seg),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] glyph8(input logic [3:0] v);
        case (v)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    function automatic logic [3:0] model_digit(input int k);
        case (k)
            0: return sec_l;
            1: return sec_h;
            2: return min_l;
            3: return min_h;
            4: return hour_l;
            default: return hour_h;
        endcase
    endfunction

    // Reference model: position in the frame is derived from edges since reset.
    initial begin
        int t, e, u, k, w;
        logic prev_en;
        logic [3:0] lat;
        logic [5:0] one;
        logic [7:0] es;
        t = 0; e = 0; prev_en = 1'b0; lat = 4'd0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0; e = 0; prev_en = 1'b0;
                sb_q.delete();
            end else begin
                t++;
                if (edit_en && !prev_en) e = 0; else e++;
                prev_en = edit_en;
                u = t % FRAME; k = u / SLOT; w = u % SLOT;
                if (w == BLNK) lat = model_digit(k);
                if (w < BLNK) begin
                    sb_q.push_back({6'h3F, 8'hFF});
                end else begin
                    one = 6'd1 << k;
                    es = glyph8(lat);
                    if (k == 2 || k == 4) es[7] = 1'b0;
`ifdef SEG_BLINK_EN
                    if (edit_en && edit_sel == 3'(k) && ((e / BLINK) % 2 == 1)) es = 8'hFF;
`endif
                    sb_q.push_back({~one, es});
                end
            end
        end
    end

    task automatic test_reset();
        logic [13:0] exp;
        rst_n = 1'b0; edit_en = 1'b0; edit_sel = 3'd0;
        sec_l = 4'd1; sec_h = 4'd2; min_l = 4'd3; min_h = 4'd4; hour_l = 4'd5; hour_h = 4'd6;
        repeat (3) @(negedge clk);
        checks++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            errors++; $display("FAIL reset_hold: sel/seg got %h/%h want 3f/ff", sel, seg);
        end
        rst_n = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL reset_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL reset_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (c < 9) begin
                checks++;
                if (c == 0 && (sel !== 6'h3F || seg !== 8'hFF)) begin
                    errors++; $display("FAIL first_gap: got %h/%h want 3f/ff", sel, seg);
                end else if (c > 0 && (sel !== 6'h3E || seg !== 8'hF9)) begin
                    errors++; $display("FAIL first_slot: cycle %0d got %h/%h want 3e/f9", c, sel, seg);
                end
            end
        end
    endtask

    task automatic test_full_scan();
        logic [13:0] exp;
        logic [7:0] want[6];
        want = '{8'h80, 8'h92, 8'h10, 8'h92, 8'h30, 8'hA4};
        sec_l = 4'd8; sec_h = 4'd5; min_l = 4'd9; min_h = 4'd5; hour_l = 4'd3; hour_h = 4'd2;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL scan_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL scan_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (c >= FRAME && sel !== 6'h3F) begin
                for (int k = 0; k < 6; k++) begin
                    if (sel === ~(6'd1 << k)) begin
                        checks++;
                        if (seg !== want[k]) begin
                            errors++; $display("FAIL scan_digit%0d: got %h want %h", k, seg, want[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_mid_slot();
        logic [13:0] exp;
        logic [5:0] prev_sel;
        bit found;
        sec_l = 4'd4;
        prev_sel = sel; found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL mid_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL mid_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (prev_sel === 6'h3F && sel === 6'h3E) found = 1'b1;
            prev_sel = sel;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_wait: idx0 slot entry not seen, sel %h want 3e", sel);
        end
        for (int c = 0; c < 4 + FRAME; c++) begin
            if (c == 3) sec_l = 4'd7;
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL mid_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL mid_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (sel === 6'h3E) begin
                checks++;
                if (c < 7 && seg !== 8'h99) begin
                    errors++; $display("FAIL mid_hold: cycle %0d got %h want 99", c, seg);
                end else if (c >= 7 && seg !== 8'hF8) begin
                    errors++; $display("FAIL mid_next: cycle %0d got %h want f8", c, seg);
                end
            end
        end
    endtask

    task automatic test_invalid_bcd();
        logic [13:0] exp;
        min_h = 4'hC;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL dash_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL dash_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (c >= FRAME && sel === 6'h37) begin
                checks++;
                if (seg !== 8'hBF) begin
                    errors++; $display("FAIL dash_glyph: got %h want bf", seg);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [13:0] exp;
        logic [5:0] prev_sel;
        bit found, want_hidden;
        prev_sel = sel; found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL blink_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL blink_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (prev_sel === 6'h3F && sel === 6'h3E) found = 1'b1;
            prev_sel = sel;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL blink_wait: idx0 slot entry not seen, sel %h want 3e", sel);
        end
        edit_en = 1'b1; edit_sel = 3'd4;
        for (int c = 0; c < 240 + FRAME; c++) begin
            if (c == 240) edit_sel = 3'd6;
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL blink_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL blink_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (c < 240 && sel === 6'h2F) begin
`ifdef SEG_BLINK_EN
                want_hidden = ((c / BLINK) % 2) == 1;
`else
                want_hidden = 1'b0;
`endif
                checks++;
                if ((seg === 8'hFF) !== want_hidden) begin
                    errors++; $display("FAIL blink_idx4: cycle %0d got %h hidden want %0d", c, seg, want_hidden);
                end
            end else if (c >= 240 && sel !== 6'h3F) begin
                checks++;
                if (seg === 8'hFF) begin
                    errors++; $display("FAIL blink_sel6: cycle %0d sel %h got seg ff want visible", c, sel);
                end
            end
        end
        edit_en = 1'b0; edit_sel = 3'd0;
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp;
        logic [5:0] prev_sel;
        bit found;
        prev_sel = sel; found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL rmid_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL rmid_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (prev_sel === 6'h3F && sel === 6'h37) found = 1'b1;
            prev_sel = sel;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rmid_wait: idx3 slot entry not seen, sel %h want 37", sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            errors++; $display("FAIL rmid_async: got %h/%h want 3f/ff", sel, seg);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * SLOT; c++) begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL rmid_sb: cycle %0d no expected entry", c);
            end else begin
                exp = sb_q.pop_front();
                if ({sel, seg} !== exp) begin
                    errors++; $display("FAIL rmid_sb: cycle %0d got %h/%h want %h/%h", c, sel, seg, exp[13:8], exp[7:0]);
                end
            end
            if (c < 9) begin
                checks++;
                if (c == 0 && sel !== 6'h3F) begin
                    errors++; $display("FAIL rmid_gap: got sel %h want 3f", sel);
                end else if (c > 0 && sel !== 6'h3E) begin
                    errors++; $display("FAIL rmid_slot0: cycle %0d got sel %h want 3e", c, sel);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_mid_slot();
        test_invalid_bcd();
        test_blink();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
